// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_arb_pkg                                                          |
// | Shared client ID type and default sizing for the DDR port arbiter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ddr_arb_pkg;

  typedef logic client_id_t;

  localparam client_id_t CLIENT_CAPTURE = 1'b0;
  localparam client_id_t CLIENT_HOST    = 1'b1;

  localparam int DEF_ADX_W           = 27;
  localparam int DEF_DATA_W          = 128;
  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_BURST_LIMIT     = 8;

endpackage
`default_nettype wire

// File: rtl/ddr_arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_arb_tag_fifo                                                     |
// | In-order FIFO of client IDs, one entry per outstanding read.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ddr_arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  client_id_t                 i_push_id,
  input  logic                       i_pop,
  output client_id_t                 o_head_id,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  client_id_t [DEPTH-1:0] slots_q, slots_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign w_empty = (count_q == '0);

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (w_do_push) begin
      slots_d[wr_ptr_q] = i_push_id;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slots_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slots_q  <= slots_d;
    end
  end

  assign o_head_id = slots_q[rd_ptr_q];
  assign o_count   = count_q;
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_port_arbiter                                                     |
// | Two-client arbiter for the DDR request/return port, with burst-      |
// | limited ownership and in-order read return routing.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADX_W           = DEF_ADX_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int BURST_LIMIT     = DEF_BURST_LIMIT
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              c0_req_valid,
  output logic                              c0_req_ready,
  input  logic                              c0_req_we,
  input  logic [ADX_W-1:0]                  c0_req_adx,
  input  logic [DATA_W-1:0]                 c0_req_wdata,
  output logic                              c0_rsp_valid,
  input  logic                              c0_rsp_ready,
  output logic [DATA_W-1:0]                 c0_rsp_data,
  output logic [ADX_W-1:0]                  c0_rsp_adx,

  input  logic                              c1_req_valid,
  output logic                              c1_req_ready,
  input  logic                              c1_req_we,
  input  logic [ADX_W-1:0]                  c1_req_adx,
  input  logic [DATA_W-1:0]                 c1_req_wdata,
  output logic                              c1_rsp_valid,
  input  logic                              c1_rsp_ready,
  output logic [DATA_W-1:0]                 c1_rsp_data,
  output logic [ADX_W-1:0]                  c1_rsp_adx,

  output logic                              mem_write_req,
  output logic                              mem_read_req,
  output logic [ADX_W-1:0]                  mem_wr_adx,
  output logic [ADX_W-1:0]                  mem_rd_adx,
  output logic [DATA_W-1:0]                 mem_wr_data,
  input  logic                              mem_write_allowed,
  input  logic                              mem_read_allowed,
  input  logic [DATA_W-1:0]                 mem_rd_data,
  input  logic [ADX_W-1:0]                  mem_rd_adx_ret,
  input  logic                              mem_has_return_data,
  output logic                              mem_get_return_data,

  output logic [$clog2(MAX_OUTSTANDING):0]  reads_outstanding,
  output logic                              err_orphan
);

  localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BURST_W = $clog2(BURST_LIMIT + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LIMIT);

  client_id_t         owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               err_orphan_q, err_orphan_d;

  client_id_t         w_grant;
  client_id_t         w_other;
  logic               w_owner_valid;
  logic               w_other_valid;
  logic               w_g_valid;
  logic               w_g_we;
  logic [ADX_W-1:0]   w_g_adx;
  logic [DATA_W-1:0]  w_g_wdata;
  logic               w_g_ready;
  logic               w_xfer;

  client_id_t         w_head;
  logic               w_head_ready;
  logic               w_rsp_valid;
  logic               w_tag_full;
  logic               w_tag_empty;
  logic [CNT_W-1:0]   w_tag_count;

  // Grant selection: the owner keeps the port until its burst budget runs
  // out while the other client is waiting.
  always_comb begin
    w_other       = ~owner_q;
    w_owner_valid = (owner_q == CLIENT_HOST) ? c1_req_valid : c0_req_valid;
    w_other_valid = (owner_q == CLIENT_HOST) ? c0_req_valid : c1_req_valid;
    w_grant       = owner_q;
    if (w_owner_valid && ((burst_q < BURST_MAX) || !w_other_valid)) begin
      w_grant = owner_q;
    end else if (w_other_valid) begin
      w_grant = w_other;
    end
  end

  always_comb begin
    if (w_grant == CLIENT_HOST) begin
      w_g_valid = c1_req_valid;
      w_g_we    = c1_req_we;
      w_g_adx   = c1_req_adx;
      w_g_wdata = c1_req_wdata;
    end else begin
      w_g_valid = c0_req_valid;
      w_g_we    = c0_req_we;
      w_g_adx   = c0_req_adx;
      w_g_wdata = c0_req_wdata;
    end
  end

  assign w_g_ready = !rst && (w_g_we ? mem_write_allowed
                                     : (mem_read_allowed && !w_tag_full));
  assign w_xfer    = w_g_valid && w_g_ready;

  assign c0_req_ready = w_g_ready && (w_grant == CLIENT_CAPTURE);
  assign c1_req_ready = w_g_ready && (w_grant == CLIENT_HOST);

  assign mem_write_req = w_xfer && w_g_we;
  assign mem_read_req  = w_xfer && !w_g_we;
  assign mem_wr_adx    = w_g_adx;
  assign mem_rd_adx    = w_g_adx;
  assign mem_wr_data   = w_g_wdata;

  // Return routing follows the oldest outstanding tag.
  assign w_rsp_valid  = !rst && mem_has_return_data && !w_tag_empty;
  assign w_head_ready = (w_head == CLIENT_HOST) ? c1_rsp_ready : c0_rsp_ready;

  assign c0_rsp_valid        = w_rsp_valid && (w_head == CLIENT_CAPTURE);
  assign c1_rsp_valid        = w_rsp_valid && (w_head == CLIENT_HOST);
  assign mem_get_return_data = w_rsp_valid && w_head_ready;

  assign c0_rsp_data = mem_rd_data;
  assign c1_rsp_data = mem_rd_data;
  assign c0_rsp_adx  = mem_rd_adx_ret;
  assign c1_rsp_adx  = mem_rd_adx_ret;

  always_comb begin
    owner_d      = owner_q;
    burst_d      = burst_q;
    err_orphan_d = err_orphan_q || (mem_has_return_data && w_tag_empty);
    if (w_xfer) begin
      if (w_grant == owner_q) begin
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);
      end else begin
        owner_d = w_grant;
        burst_d = BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= CLIENT_CAPTURE;
      burst_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  ddr_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (mem_read_req),
    .i_push_id (w_grant),
    .i_pop     (mem_get_return_data),
    .o_head_id (w_head),
    .o_count   (w_tag_count),
    .o_full    (w_tag_full),
    .o_empty   (w_tag_empty)
  );

  assign reads_outstanding = w_tag_count;
  assign err_orphan        = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ddr_port_arbiter                                                  |
// | Randomized and directed stimulus against a queue-based model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ddr_port_arbiter;

  localparam int ADX_W  = 27;
  localparam int DATA_W = 128;
  localparam int MAXO   = 16;
  localparam int BL     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic c0_req_valid, c0_req_ready, c0_req_we, c0_rsp_valid, c0_rsp_ready;
  logic c1_req_valid, c1_req_ready, c1_req_we, c1_rsp_valid, c1_rsp_ready;
  logic [ADX_W-1:0]  c0_req_adx, c1_req_adx, c0_rsp_adx, c1_rsp_adx;
  logic [DATA_W-1:0] c0_req_wdata, c1_req_wdata, c0_rsp_data, c1_rsp_data;
  logic mem_write_req, mem_read_req, mem_write_allowed, mem_read_allowed;
  logic mem_has_return_data, mem_get_return_data;
  logic [ADX_W-1:0]  mem_wr_adx, mem_rd_adx, mem_rd_adx_ret;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;
  logic [$clog2(MAXO):0] reads_outstanding;
  logic err_orphan;

  ddr_port_arbiter #(
    .ADX_W(ADX_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .BURST_LIMIT(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_we(c0_req_we),
    .c0_req_adx(c0_req_adx), .c0_req_wdata(c0_req_wdata), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_ready(c0_rsp_ready), .c0_rsp_data(c0_rsp_data), .c0_rsp_adx(c0_rsp_adx),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_we(c1_req_we),
    .c1_req_adx(c1_req_adx), .c1_req_wdata(c1_req_wdata), .c1_rsp_valid(c1_rsp_valid),
    .c1_rsp_ready(c1_rsp_ready), .c1_rsp_data(c1_rsp_data), .c1_rsp_adx(c1_rsp_adx),
    .mem_write_req(mem_write_req), .mem_read_req(mem_read_req),
    .mem_wr_adx(mem_wr_adx), .mem_rd_adx(mem_rd_adx), .mem_wr_data(mem_wr_data),
    .mem_write_allowed(mem_write_allowed), .mem_read_allowed(mem_read_allowed),
    .mem_rd_data(mem_rd_data), .mem_rd_adx_ret(mem_rd_adx_ret),
    .mem_has_return_data(mem_has_return_data), .mem_get_return_data(mem_get_return_data),
    .reads_outstanding(reads_outstanding), .err_orphan(err_orphan)
  );

  // Stimulus staged by the sequences, applied on the next falling edge.
  logic              s_rst, s_wa, s_ra, s_ret, s_orphan;
  logic [1:0]        s_valid, s_we, s_rsp_ready;
  logic [ADX_W-1:0]  s_adx [2];
  logic [DATA_W-1:0] s_wdata [2];

  // Reference model: current owner, length of its current run of grants,
  // read tags in issue order and the addresses the memory still owes.
  int               m_owner;
  int               m_run;
  int               m_tags[$];
  logic [ADX_W-1:0] m_pend[$];
  bit               m_err;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [DATA_W-1:0] data_of(logic [ADX_W-1:0] a);
    logic [31:0] x;
    x = {5'd0, a};
    return {x, ~x, x + 32'd7, x ^ 32'h5A5A_A5A5};
  endfunction

  task automatic check_eq(string tag, logic [DATA_W-1:0] obs, logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic stage_idle();
    s_rst = 1'b0; s_wa = 1'b1; s_ra = 1'b1; s_ret = 1'b0; s_orphan = 1'b0;
    s_valid = 2'b00; s_we = 2'b00; s_rsp_ready = 2'b11;
    s_adx[0] = '0; s_adx[1] = '0; s_wdata[0] = '0; s_wdata[1] = '0;
  endtask

  task automatic step();
    int  g, other, head;
    bit  ov, xv, g_ready, xfer, rv, get;
    @(negedge clk);
    rst = s_rst;
    c0_req_valid = s_valid[0]; c0_req_we = s_we[0]; c0_req_adx = s_adx[0]; c0_req_wdata = s_wdata[0];
    c1_req_valid = s_valid[1]; c1_req_we = s_we[1]; c1_req_adx = s_adx[1]; c1_req_wdata = s_wdata[1];
    c0_rsp_ready = s_rsp_ready[0]; c1_rsp_ready = s_rsp_ready[1];
    mem_write_allowed = s_wa; mem_read_allowed = s_ra;
    if (s_ret && m_pend.size() > 0) begin
      mem_has_return_data = 1'b1;
      mem_rd_adx_ret = m_pend[0];
      mem_rd_data = data_of(m_pend[0]);
    end else if (s_orphan && m_tags.size() == 0) begin
      mem_has_return_data = 1'b1;
      mem_rd_adx_ret = ADX_W'($urandom);
      mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      mem_has_return_data = 1'b0;
    end
    #1;
    check_eq("reads_outstanding", reads_outstanding, m_tags.size());
    check_eq("err_orphan", err_orphan, m_err);

    if (s_rst) begin
      check_eq("rst_c0_req_ready", c0_req_ready, 0);
      check_eq("rst_c1_req_ready", c1_req_ready, 0);
      check_eq("rst_c0_rsp_valid", c0_rsp_valid, 0);
      check_eq("rst_c1_rsp_valid", c1_rsp_valid, 0);
      check_eq("rst_mem_write_req", mem_write_req, 0);
      check_eq("rst_mem_read_req", mem_read_req, 0);
      check_eq("rst_mem_get", mem_get_return_data, 0);
      m_owner = 0; m_run = 0; m_err = 0;
      m_tags.delete(); m_pend.delete();
      return;
    end

    other = 1 - m_owner;
    ov = s_valid[m_owner];
    xv = s_valid[other];
    if (ov && (m_run < BL || !xv)) g = m_owner;
    else if (xv) g = other;
    else g = m_owner;
    g_ready = s_we[g] ? s_wa : (s_ra && m_tags.size() < MAXO);
    xfer = s_valid[g] && g_ready;

    if (s_valid[0]) check_eq("c0_req_ready", c0_req_ready, (g == 0) && g_ready);
    if (s_valid[1]) check_eq("c1_req_ready", c1_req_ready, (g == 1) && g_ready);
    check_eq("mem_write_req", mem_write_req, xfer && s_we[g]);
    check_eq("mem_read_req", mem_read_req, xfer && !s_we[g]);
    if (xfer && s_we[g]) begin
      check_eq("mem_wr_adx", mem_wr_adx, s_adx[g]);
      check_eq("mem_wr_data", mem_wr_data, s_wdata[g]);
    end
    if (xfer && !s_we[g]) check_eq("mem_rd_adx", mem_rd_adx, s_adx[g]);

    rv   = mem_has_return_data && m_tags.size() > 0;
    head = (m_tags.size() > 0) ? m_tags[0] : 0;
    get  = rv && s_rsp_ready[head];
    check_eq("c0_rsp_valid", c0_rsp_valid, rv && head == 0);
    check_eq("c1_rsp_valid", c1_rsp_valid, rv && head == 1);
    check_eq("mem_get_return_data", mem_get_return_data, get);
    if (rv) begin
      check_eq("rsp_adx", (head == 0) ? c0_rsp_adx : c1_rsp_adx, m_pend[0]);
      check_eq("rsp_data", (head == 0) ? c0_rsp_data : c1_rsp_data, data_of(m_pend[0]));
    end

    if (mem_has_return_data && m_tags.size() == 0) m_err = 1;
    if (xfer) begin
      if (g == m_owner) m_run = (m_run < BL) ? m_run + 1 : BL;
      else begin m_owner = g; m_run = 1; end
      if (!s_we[g]) begin
        m_tags.push_back(g);
        m_pend.push_back(s_adx[g]);
      end
    end
    if (get) begin
      void'(m_tags.pop_front());
      void'(m_pend.pop_front());
    end
  endtask

  task automatic issue(int c, bit we, int adx);
    stage_idle();
    s_valid[c] = 1'b1;
    s_we[c] = we;
    s_adx[c] = ADX_W'(adx);
    s_wdata[c] = {$urandom, $urandom, $urandom, $urandom};
    step();
  endtask

  initial begin
    m_owner = 0; m_run = 0; m_err = 0;
    rst = 1'b1;
    c0_req_valid = 0; c0_req_we = 0; c0_req_adx = '0; c0_req_wdata = '0; c0_rsp_ready = 0;
    c1_req_valid = 0; c1_req_we = 0; c1_req_adx = '0; c1_req_wdata = '0; c1_rsp_ready = 0;
    mem_write_allowed = 0; mem_read_allowed = 0; mem_has_return_data = 0;
    mem_rd_adx_ret = '0; mem_rd_data = '0;

    stage_idle(); s_rst = 1'b1;
    repeat (3) step();

    // Write stream from the capture client.
    for (int i = 0; i < 4; i++) issue(0, 1'b1, i);

    // Both clients streaming writes: alternating bursts of BL grants.
    stage_idle(); s_valid = 2'b11; s_we = 2'b11;
    for (int i = 0; i < 40; i++) begin
      s_adx[0] = ADX_W'(i); s_adx[1] = ADX_W'(i + 100);
      s_wdata[0] = {4{$urandom}}; s_wdata[1] = {4{$urandom}};
      step();
    end

    // Interleaved reads returned in order.
    issue(0, 1'b0, 'h10);
    issue(1, 1'b0, 'h20);
    issue(0, 1'b0, 'h30);
    stage_idle(); s_ret = 1'b1;
    repeat (4) step();

    // Fill the tag FIFO; further reads stall while writes still pass.
    for (int i = 0; i < MAXO; i++) issue(0, 1'b0, 'h100 + i);
    stage_idle(); s_valid = 2'b11; s_we = 2'b10; s_adx[0] = 'h200; s_adx[1] = 'h300;
    repeat (3) step();
    stage_idle(); s_ret = 1'b1;
    step();
    issue(0, 1'b0, 'h201);
    stage_idle(); s_ret = 1'b1;
    repeat (MAXO + 2) step();

    // Return held while the client is not ready.
    issue(1, 1'b0, 'h55);
    stage_idle(); s_ret = 1'b1; s_rsp_ready = 2'b00;
    repeat (5) step();
    s_rsp_ready = 2'b11;
    repeat (2) step();

    // Orphan return, then reset with reads in flight.
    stage_idle(); s_orphan = 1'b1;
    step();
    stage_idle();
    repeat (3) step();
    issue(1, 1'b0, 'h66);
    issue(0, 1'b0, 'h67);
    stage_idle(); s_rst = 1'b1;
    step();
    stage_idle();
    repeat (2) step();

    // Randomized traffic, alternating drain-heavy and fill-heavy phases.
    for (int i = 0; i < 4000; i++) begin
      bit fill_phase;
      fill_phase = ((i / 500) % 2) == 1;
      s_rst = ($urandom_range(0, 399) == 0);
      s_valid = 2'($urandom);
      s_we = 2'($urandom);
      s_adx[0] = ADX_W'($urandom); s_adx[1] = ADX_W'($urandom);
      s_wdata[0] = {$urandom, $urandom, $urandom, $urandom};
      s_wdata[1] = {$urandom, $urandom, $urandom, $urandom};
      s_wa = ($urandom_range(0, 3) != 0);
      s_ra = ($urandom_range(0, 3) != 0);
      s_ret = fill_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      s_rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      s_orphan = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
